lcd_cmd_sched: RTL and testbench

LCD_CMD_SCHED -- requirements
Module: lcd_cmd_sched

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_cmd_fifo.sv | 53 +++++
 rtl/lcd_cmd_sched.sv | 143 ++++++++++++++
 tb/tb_lcd_cmd_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler: opcode set, scheduler
// states and the opcode legality check.
package lcd_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 8;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_WRITE      = 4'd0;
  localparam opcode_t OP_READ       = 4'd1;
  localparam opcode_t OP_CLEAR      = 4'd2;
  localparam opcode_t OP_FILL       = 4'd3;
  localparam opcode_t OP_SCROLL     = 4'd4;
  localparam opcode_t OP_ROTATE     = 4'd5;
  localparam opcode_t OP_INVERT     = 4'd6;
  localparam opcode_t OP_BRIGHTNESS = 4'd7;
  localparam opcode_t OP_CONTRAST   = 4'd8;
  localparam opcode_t OP_SLEEP      = 4'd9;
  localparam opcode_t OP_MIRROR_X   = 4'd10;
  localparam opcode_t OP_MIRROR_Y   = 4'd11;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_IDLE = 3'd1,
    ST_ACK  = 3'd2,
    ST_RUN  = 3'd3,
    ST_FIN  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Opcodes above Mirror_Y are reserved and never reach the FIFO.
  function automatic logic is_legal(input opcode_t op);
    return (op <= OP_MIRROR_Y);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command FIFO: power-of-2 depth, combinational head, level counter.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned  DEPTH = 8,
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  opcode_t       i_data,
  input  logic          i_pop,
  output opcode_t       o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  opcode_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
    end
  end

  // Storage needs no reset: the level counter guards every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/lcd_cmd_sched.sv
// LCD command scheduler: buffers host opcodes and issues them one at a time
// to the LCD controller with a busy/done handshake and a handshake watchdog.
module lcd_cmd_sched
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] host_cmd,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [3:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  input  logic       lcd_busy,
  input  logic       lcd_done,
  output logic [3:0] fifo_level,
  output logic [7:0] issued_cnt,
  output logic       illegal_flag,
  output logic       timeout_err,
  output logic       sched_done
);

  localparam int unsigned LW = $clog2(DEPTH + 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_tmo;
  logic [CNT_W-1:0] r_issued;
  opcode_t          r_lcd_cmd;
  logic             r_lcd_cmd_valid;
  logic             r_illegal;
  logic             r_timeout_err;
  logic             r_sched_done;

  logic             w_full;
  logic             w_empty;
  logic             w_hs;
  logic             w_push;
  logic             w_pop;
  logic             w_tmo_hit;
  opcode_t          w_head;
  logic [LW-1:0]    w_level;

  // Intake stops once the schedule has finished or failed.
  assign host_ready = !w_full && !r_sched_done && !r_timeout_err;
  assign w_hs       = host_valid && host_ready;
  assign w_push     = w_hs && is_legal(host_cmd);
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_tmo_hit  = (r_tmo == CNT_W'(TIMEOUT - 1));

  assign lcd_cmd       = r_lcd_cmd;
  assign lcd_cmd_valid = r_lcd_cmd_valid;
  assign fifo_level    = 4'(w_level);
  assign issued_cnt    = r_issued;
  assign illegal_flag  = r_illegal;
  assign timeout_err   = r_timeout_err;
  assign sched_done    = r_sched_done;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (host_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_illegal <= 1'b0;
    end else if (w_hs && !is_legal(host_cmd)) begin
      r_illegal <= 1'b1;
    end
  end

  // Scheduler FSM; the watchdog restarts on every ACK and RUN entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_BOOT;
      r_tmo           <= '0;
      r_issued        <= '0;
      r_lcd_cmd       <= '0;
      r_lcd_cmd_valid <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_sched_done    <= 1'b0;
    end else begin
      r_lcd_cmd_valid <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          if (!lcd_busy) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!w_empty) begin
            r_lcd_cmd       <= w_head;
            r_lcd_cmd_valid <= 1'b1;
            if (r_issued != '1) r_issued <= r_issued + CNT_W'(1);
            r_tmo           <= '0;
            r_state         <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (lcd_busy) begin
            r_tmo   <= '0;
            r_state <= ST_RUN;
          end else if (w_tmo_hit) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_ERR;
          end else begin
            r_tmo <= r_tmo + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lcd_busy) begin
            if ((r_lcd_cmd == OP_WRITE) && lcd_done) begin
              r_sched_done <= 1'b1;
              r_state      <= ST_FIN;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_tmo_hit) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_ERR;
          end else begin
            r_tmo <= r_tmo + CNT_W'(1);
          end
        end
        ST_FIN, ST_ERR: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Self-checking bench for lcd_cmd_sched: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_lcd_cmd_sched;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 200;
  localparam int NV      = 12;
  localparam int RND_TARGET = 262;
  localparam int RND_CAP    = 6000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy;
  logic       lcd_done;
  logic [3:0] fifo_level;
  logic [7:0] issued_cnt;
  logic       illegal_flag;
  logic       timeout_err;
  logic       sched_done;

  always #5 clk = ~clk;

  lcd_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_cmd      (host_cmd),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .fifo_level    (fifo_level),
    .issued_cnt    (issued_cnt),
    .illegal_flag  (illegal_flag),
    .timeout_err   (timeout_err),
    .sched_done    (sched_done)
  );

  typedef struct {
    logic       v;
    logic [3:0] cmd;
    int         lvl;
    logic       rdy;
    logic       ill;
  } vec_t;

  vec_t       vecs [NV];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] q [$];
  logic [3:0] got;
  logic [3:0] pend_cmd;
  logic [3:0] exp_seq [4];
  logic [3:0] exp_tab [8];
  bit         ok;
  bit         pend;
  bit         ill_exp;
  bit         prev_v;
  int         strobes;
  int         cnt;
  int         dly;
  int         bsy;
  int         cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_valid"}, 32'(lcd_cmd_valid), 32'd0);
    chk({tag, "_cmd"}, 32'(lcd_cmd), 32'd0);
    chk({tag, "_issued"}, 32'(issued_cnt), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal_flag), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    chk({tag, "_done"}, 32'(sched_done), 32'd0);
    chk({tag, "_ready"}, 32'(host_ready), 32'd1);
  endtask

  task automatic do_reset(input logic busy);
    reset      = 1'b0;
    host_valid = 1'b0;
    host_cmd   = 4'd0;
    lcd_done   = 1'b0;
    lcd_busy   = busy;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
  endtask

  task automatic push(input logic [3:0] c);
    host_valid = 1'b1;
    host_cmd   = c;
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  // Model LCD: busy for nb cycles after the strobe, then drop busy with done.
  task automatic serve(input int nb, input logic dn, output logic [3:0] c, output bit found);
    int t;
    t = 0;
    found = 1'b0;
    c = 4'd0;
    while (!lcd_cmd_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (lcd_cmd_valid) begin
      found = 1'b1;
      c = lcd_cmd;
      lcd_busy = 1'b1;
      repeat (nb) @(negedge clk);
      lcd_busy = 1'b0;
      lcd_done = dn;
      @(negedge clk);
      lcd_done = 1'b0;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'd3,  1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 4'd8,  1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'd13, 1, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 4'd5,  2, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 4'd7,  3, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 4'd11, 4, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 4'd0,  5, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 4'd1,  6, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 4'd2,  7, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 4'd4,  8, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 4'd6,  8, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 4'd15, 8, 1'b0, 1'b1};
    exp_tab[0] = 4'd3; exp_tab[1] = 4'd5; exp_tab[2] = 4'd7; exp_tab[3] = 4'd11;
    exp_tab[4] = 4'd0; exp_tab[5] = 4'd1; exp_tab[6] = 4'd2; exp_tab[7] = 4'd4;
    exp_seq[0] = 4'd1; exp_seq[1] = 4'd5; exp_seq[2] = 4'd9; exp_seq[3] = 4'd0;

    // Fill in BOOT with the LCD busy: backpressure and illegal drop.
    do_reset(1'b1);
    for (int i = 0; i < NV; i++) begin
      host_valid = vecs[i].v;
      host_cmd   = vecs[i].cmd;
      @(negedge clk);
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d_ready", i), 32'(host_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_illegal", i), 32'(illegal_flag), 32'(vecs[i].ill));
      chk($sformatf("vec%0d_issued", i), 32'(issued_cnt), 32'd0);
      chk($sformatf("vec%0d_strobe", i), 32'(lcd_cmd_valid), 32'd0);
    end
    host_valid = 1'b0;
    lcd_busy   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      serve(1, 1'b0, got, ok);
      chk($sformatf("tab_issue%0d_seen", i), 32'(ok), 32'd1);
      chk($sformatf("tab_issue%0d_cmd", i), 32'(got), 32'(exp_tab[i]));
    end
    chk("tab_drained_level", 32'(fifo_level), 32'd0);
    chk("tab_issued", 32'(issued_cnt), 32'd8);
    chk("tab_write_nodone", 32'(sched_done), 32'd0);
    chk("tab_ready", 32'(host_ready), 32'd1);

    // Randomized traffic against the queue model, run past counter saturation.
    do_reset(1'b0);
    q.delete();
    strobes = 0; ill_exp = 1'b0; pend = 1'b0; pend_cmd = 4'd0;
    prev_v = 1'b0; dly = 0; bsy = 0; cyc = 0;
    while ((strobes < RND_TARGET || q.size() != 0) && cyc < RND_CAP) begin
      @(negedge clk);
      cyc++;
      if (lcd_cmd_valid) begin
        chk("rnd_issue_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) chk("rnd_issue_order", 32'(lcd_cmd), 32'(q.pop_front()));
        strobes++;
      end
      if (pend) begin
        if (pend_cmd <= 4'd11) q.push_back(pend_cmd);
        else ill_exp = 1'b1;
      end
      chk("rnd_level", 32'(fifo_level), 32'(q.size()));
      chk("rnd_ready", 32'(host_ready), 32'(q.size() < DEPTH));
      chk("rnd_illegal", 32'(illegal_flag), 32'(ill_exp));
      chk("rnd_issued", 32'(issued_cnt), 32'((strobes > 255) ? 255 : strobes));
      chk("rnd_strobe_width", 32'(prev_v && lcd_cmd_valid), 32'd0);
      prev_v = lcd_cmd_valid;
      if (lcd_cmd_valid) begin
        dly = $urandom_range(0, 3);
        bsy = $urandom_range(1, 5);
      end else if (dly > 0) dly--;
      else if (bsy > 0) bsy--;
      lcd_busy   = (dly == 0) && (bsy > 0);
      pend       = (strobes < RND_TARGET) && ($urandom_range(0, 99) < 45);
      pend_cmd   = 4'($urandom_range(0, 15));
      host_valid = pend;
      host_cmd   = pend_cmd;
      pend       = pend && (q.size() < DEPTH);
    end
    host_valid = 1'b0;
    chk("rnd_completed", 32'(cyc < RND_CAP), 32'd1);
    chk("rnd_saturated", 32'(issued_cnt), 32'd255);

    // Long boot: nothing issues while the LCD preload keeps busy high.
    do_reset(1'b1);
    push(4'd3);
    cnt = lcd_cmd_valid ? 1 : 0;
    repeat (69) begin
      @(negedge clk);
      if (lcd_cmd_valid) cnt++;
    end
    chk("boot_no_strobe", 32'(cnt), 32'd0);
    chk("boot_level", 32'(fifo_level), 32'd1);
    lcd_busy = 1'b0;
    @(negedge clk);
    chk("boot_exit_no_strobe", 32'(lcd_cmd_valid), 32'd0);
    @(negedge clk);
    chk("boot_strobe", 32'(lcd_cmd_valid), 32'd1);
    chk("boot_cmd", 32'(lcd_cmd), 32'd3);
    @(negedge clk);
    chk("boot_strobe_single", 32'(lcd_cmd_valid), 32'd0);
    chk("boot_cmd_hold", 32'(lcd_cmd), 32'd3);

    // One-cycle issue latency, then a watchdog expiry in ACK.
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    push(4'd9);
    chk("lat_push_no_strobe", 32'(lcd_cmd_valid), 32'd0);
    chk("lat_level", 32'(fifo_level), 32'd1);
    @(negedge clk);
    chk("lat_strobe", 32'(lcd_cmd_valid), 32'd1);
    chk("lat_cmd", 32'(lcd_cmd), 32'd9);
    chk("lat_popped", 32'(fifo_level), 32'd0);
    cnt = 0;
    for (int n = 1; n < TIMEOUT; n++) begin
      @(negedge clk);
      if (timeout_err) cnt++;
    end
    chk("tmo_not_early", 32'(cnt), 32'd0);
    @(negedge clk);
    chk("tmo_at_limit", 32'(timeout_err), 32'd1);
    chk("tmo_ready", 32'(host_ready), 32'd0);
    chk("tmo_cmd_hold", 32'(lcd_cmd), 32'd9);
    host_valid = 1'b1;
    host_cmd   = 4'd2;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (lcd_cmd_valid) cnt++;
    end
    host_valid = 1'b0;
    chk("tmo_no_strobe", 32'(cnt), 32'd0);
    chk("tmo_no_push", 32'(fifo_level), 32'd0);

    // Sequence ending in a Write that completes with lcd_done.
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) push(exp_seq[i]);
    lcd_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve((i == 3) ? 65 : 1, (i == 3), got, ok);
      chk($sformatf("seq_issue%0d_seen", i), 32'(ok), 32'd1);
      chk($sformatf("seq_issue%0d_cmd", i), 32'(got), 32'(exp_seq[i]));
    end
    chk("seq_issued", 32'(issued_cnt), 32'd4);
    chk("seq_done", 32'(sched_done), 32'd1);
    chk("seq_ready", 32'(host_ready), 32'd0);
    chk("seq_no_timeout", 32'(timeout_err), 32'd0);
    host_valid = 1'b1;
    host_cmd   = 4'd4;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (lcd_cmd_valid) cnt++;
    end
    host_valid = 1'b0;
    chk("fin_no_strobe", 32'(cnt), 32'd0);

    // Reset pulse while the LCD is running a command.
    do_reset(1'b1);
    push(4'd2);
    push(4'd4);
    lcd_busy = 1'b0;
    cnt = 0;
    while (!lcd_cmd_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("mid_first_issue", 32'(lcd_cmd_valid), 32'd1);
    lcd_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_pre_issued", 32'(issued_cnt), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_vals("mid");
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (lcd_cmd_valid) cnt++;
    end
    chk("mid_boot_no_strobe", 32'(cnt), 32'd0);
    chk("mid_fifo_empty", 32'(fifo_level), 32'd0);
    push(4'd6);
    lcd_busy = 1'b0;
    serve(1, 1'b0, got, ok);
    chk("mid_reissue_seen", 32'(ok), 32'd1);
    chk("mid_reissue_cmd", 32'(got), 32'd6);
    chk("mid_reissue_cnt", 32'(issued_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
